// File: rtl/id_stage.sv
// Decode-and-rename stage for the 2-wide, 2-thread out-of-order core.
// Decodes two Alpha instructions per cycle and renames them through a per-thread RAT.
`ifndef PR_BITS
`define PR_BITS 7
`endif

package id_stage_pkg;

    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef logic [`PR_BITS-1:0] prn_t;
    typedef prn_t [31:0] RAT_ARR;

    typedef enum logic [1:0] {OPA_REGA, OPA_NPC, OPA_MEM_DISP, OPA_ZERO} opa_sel_t;
    typedef enum logic [1:0] {OPB_REGB, OPB_LIT, OPB_BR_DISP, OPB_ZERO} opb_sel_t;

    typedef enum logic [4:0] {
        ALU_ADDQ, ALU_SUBQ, ALU_AND, ALU_BIC, ALU_BIS, ALU_ORNOT, ALU_XOR, ALU_EQV,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULQ, ALU_CMPEQ, ALU_CMPLT, ALU_CMPLE,
        ALU_CMPULT, ALU_CMPULE
    } alu_func_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [63:0] NPC;
        logic        thread_id;
    } IF_ID;

    typedef struct packed {
        logic        valid;
        logic        thread_id;
        logic [63:0] NPC;
        logic [31:0] inst;
        opa_sel_t    opa_select;
        opb_sel_t    opb_select;
        alu_func_t   alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        cond_branch;
        logic        uncond_branch;
        logic        halt;
        logic        illegal;
        logic [4:0]  rega;
        logic [4:0]  regb;
        logic [4:0]  dest;
        prn_t        rega_prn;
        prn_t        regb_prn;
        prn_t        dest_prn;
    } ID_DISPATCH;

    typedef struct packed {
        logic alloc_en;
        prn_t new_PRN;
        prn_t old_PRN;
    } RAT_PRF;

endpackage

module id_stage
    import id_stage_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mispredict_thread_0,
    input  logic                          mispredict_thread_1,
    input  IF_ID       [1:0]              inst_in,
    input  logic       [1:0][`PR_BITS-1:0] free_PRN,
    input  RAT_ARR     [1:0]              RRAT_arr,
    output ID_DISPATCH [1:0]              inst_dispatch,
    output RAT_PRF     [1:0]              inst_PRF
);

    RAT_ARR [1:0] rat;
    RAT_ARR [1:0] rat_next;

    // Static decode only; valid, NPC, thread and PRNs are filled in by the caller.
    function automatic ID_DISPATCH decode(input logic [31:0] inst);
        ID_DISPATCH d;
        logic [5:0] opc;
        logic [6:0] fn;
        d            = '0;
        opc          = inst[31:26];
        fn           = inst[11:5];
        d.inst       = inst;
        d.opa_select = OPA_REGA;
        d.opb_select = OPB_REGB;
        d.alu_func   = ALU_ADDQ;
        d.rega       = ZERO_REG;
        d.regb       = ZERO_REG;
        d.dest       = ZERO_REG;
        case (opc)
            6'h10, 6'h11, 6'h12, 6'h13: begin
                d.rega = inst[25:21];
                d.dest = inst[4:0];
                if (inst[12]) d.opb_select = OPB_LIT;
                else          d.regb       = inst[20:16];
                case (opc)
                    6'h10: case (fn)
                        7'h20:   d.alu_func = ALU_ADDQ;
                        7'h29:   d.alu_func = ALU_SUBQ;
                        7'h2d:   d.alu_func = ALU_CMPEQ;
                        7'h4d:   d.alu_func = ALU_CMPLT;
                        7'h6d:   d.alu_func = ALU_CMPLE;
                        7'h1d:   d.alu_func = ALU_CMPULT;
                        7'h3d:   d.alu_func = ALU_CMPULE;
                        default: d.illegal  = 1'b1;
                    endcase
                    6'h11: case (fn)
                        7'h00:   d.alu_func = ALU_AND;
                        7'h08:   d.alu_func = ALU_BIC;
                        7'h20:   d.alu_func = ALU_BIS;
                        7'h28:   d.alu_func = ALU_ORNOT;
                        7'h40:   d.alu_func = ALU_XOR;
                        7'h48:   d.alu_func = ALU_EQV;
                        default: d.illegal  = 1'b1;
                    endcase
                    6'h12: case (fn)
                        7'h39:   d.alu_func = ALU_SLL;
                        7'h34:   d.alu_func = ALU_SRL;
                        7'h3c:   d.alu_func = ALU_SRA;
                        default: d.illegal  = 1'b1;
                    endcase
                    default: begin
                        if (fn == 7'h20) d.alu_func = ALU_MULQ;
                        else             d.illegal  = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h29: begin  // LDA, LDQ
                d.opa_select = OPA_MEM_DISP;
                d.regb       = inst[20:16];
                d.dest       = inst[25:21];
                d.rd_mem     = (opc == 6'h29);
            end
            6'h2d: begin         // STQ: ra is store data, no destination
                d.opa_select = OPA_MEM_DISP;
                d.rega       = inst[25:21];
                d.regb       = inst[20:16];
                d.wr_mem     = 1'b1;
            end
            6'h30, 6'h34: begin  // BR, BSR write the link register
                d.opa_select    = OPA_NPC;
                d.opb_select    = OPB_BR_DISP;
                d.dest          = inst[25:21];
                d.uncond_branch = 1'b1;
            end
            6'h1a: begin         // JSR family, target in rb
                d.opa_select    = OPA_NPC;
                d.opb_select    = OPB_ZERO;
                d.regb          = inst[20:16];
                d.dest          = inst[25:21];
                d.uncond_branch = 1'b1;
            end
            6'h38, 6'h39, 6'h3a, 6'h3b, 6'h3c, 6'h3d, 6'h3e, 6'h3f: begin
                d.opa_select  = OPA_NPC;
                d.opb_select  = OPB_BR_DISP;
                d.rega        = inst[25:21];
                d.cond_branch = 1'b1;
            end
            6'h00: begin
                if (inst[25:0] == 26'h555) d.halt    = 1'b1;
                else                       d.illegal = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    always_comb begin
        ID_DISPATCH [1:0] dec;
        logic       [1:0] tid;
        logic       [1:0] squash;
        logic       [1:0] live;
        logic       [1:0] alloc;
        prn_t       [1:0] rega_prn;
        prn_t       [1:0] regb_prn;
        prn_t       [1:0] old_prn;
        logic             bypass;

        // NOTE: every combinational output gets a default before any conditional
        // assignment; a path that leaves one unassigned would infer a latch.
        rat_next      = rat;
        inst_dispatch = '0;
        inst_PRF      = '0;
        squash        = {mispredict_thread_1, mispredict_thread_0};

        for (int s = 0; s < 2; s++) begin
            dec[s]      = decode(inst_in[s].inst);
            tid[s]      = inst_in[s].thread_id;
            live[s]     = inst_in[s].valid && !dec[s].illegal && !squash[tid[s]];
            alloc[s]    = live[s] && (dec[s].dest != ZERO_REG);
            rega_prn[s] = rat[tid[s]][dec[s].rega];
            regb_prn[s] = rat[tid[s]][dec[s].regb];
            old_prn[s]  = rat[tid[s]][dec[s].dest];
        end

        // Slot 1 sees slot 0's fresh mapping when both belong to the same thread.
        bypass = alloc[0] && (tid[1] == tid[0]);
        if (bypass && dec[1].rega == dec[0].dest) rega_prn[1] = free_PRN[0];
        if (bypass && dec[1].regb == dec[0].dest) regb_prn[1] = free_PRN[0];
        if (bypass && dec[1].dest == dec[0].dest) old_prn[1]  = free_PRN[0];

        for (int s = 0; s < 2; s++) begin
            inst_dispatch[s]           = dec[s];
            inst_dispatch[s].valid     = live[s];
            inst_dispatch[s].thread_id = tid[s];
            inst_dispatch[s].NPC       = inst_in[s].NPC;
            inst_dispatch[s].rega_prn  = rega_prn[s];
            inst_dispatch[s].regb_prn  = regb_prn[s];
            inst_dispatch[s].dest_prn  = alloc[s] ? free_PRN[s] : '0;
            inst_PRF[s].alloc_en       = alloc[s];
            inst_PRF[s].new_PRN        = alloc[s] ? free_PRN[s] : '0;
            inst_PRF[s].old_PRN        = alloc[s] ? old_prn[s]  : '0;
            // Slot 1 is written last so it wins a same-register collision.
            if (alloc[s]) rat_next[tid[s]][dec[s].dest] = free_PRN[s];
        end

        for (int t = 0; t < 2; t++) begin
            if (squash[t]) rat_next[t] = RRAT_arr[t];
        end

        if (!reset) begin
            inst_dispatch = '0;
            inst_PRF      = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the RAT is a storage array but it must be reset, because its
            // contents are the architectural-to-physical mapping the core starts from.
            for (int t = 0; t < 2; t++) begin
                for (int r = 0; r < 32; r++) begin
                    rat[t][r] <= prn_t'(32 * t + r);
                end
            end
        end else begin
            rat <= rat_next;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: reset, rename, bypass, zero register,
// mispredict recovery, mixed-thread bundles and decode classes.
module tb_id_stage;
    import id_stage_pkg::*;

    logic               clock;
    logic               reset;
    logic               mispredict_thread_0;
    logic               mispredict_thread_1;
    IF_ID       [1:0]   inst_in;
    prn_t       [1:0]   free_PRN;
    RAT_ARR     [1:0]   RRAT_arr;
    ID_DISPATCH [1:0]   inst_dispatch;
    RAT_PRF     [1:0]   inst_PRF;

    int errors = 0;
    int checks = 0;
    prn_t p;

    id_stage dut (
        .clock               (clock),
        .reset               (reset),
        .mispredict_thread_0 (mispredict_thread_0),
        .mispredict_thread_1 (mispredict_thread_1),
        .inst_in             (inst_in),
        .free_PRN            (free_PRN),
        .RRAT_arr            (RRAT_arr),
        .inst_dispatch       (inst_dispatch),
        .inst_PRF            (inst_PRF)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] op_inst(input logic [5:0] opc, input logic [4:0] ra,
                                            input logic [4:0] rb, input logic [6:0] fn,
                                            input logic [4:0] rc);
        return {opc, ra, rb, 3'b000, 1'b0, fn, rc};
    endfunction

    function automatic logic [31:0] mem_inst(input logic [5:0] opc, input logic [4:0] ra,
                                             input logic [4:0] rb, input logic [15:0] disp);
        return {opc, ra, rb, disp};
    endfunction

    task automatic clear_inputs();
        inst_in             = '0;
        free_PRN            = '0;
        mispredict_thread_0 = 1'b0;
        mispredict_thread_1 = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic tid, input logic [31:0] inst,
                            input prn_t free);
        inst_in[s].valid     = 1'b1;
        inst_in[s].inst      = inst;
        inst_in[s].NPC       = 64'h1000 + 64'(s * 4);
        inst_in[s].thread_id = tid;
        free_PRN[s]          = free;
    endtask

    task automatic default_rrat();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 32; r++)
                RRAT_arr[t][r] = prn_t'(32 * t + r);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Reads the current mapping of (tid, r) through a side-effect-free rename of "addq r,r31,r31".
    task automatic probe(input logic tid, input logic [4:0] r, output prn_t prn);
        @(negedge clock);
        clear_inputs();
        set_slot(0, tid, op_inst(6'h10, r, 5'd31, 7'h20, 5'd31), prn_t'(0));
        #1;
        prn = inst_dispatch[0].rega_prn;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(40));
        set_slot(1, 1'b1, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd4), prn_t'(41));
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %0d expected 0", inst_dispatch[0].valid); end
        checks++; if (inst_dispatch[1].valid !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %0d expected 0", inst_dispatch[1].valid); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL reset_alloc0: got %0d expected 0", inst_PRF[0].alloc_en); end
        checks++; if (inst_PRF[1].alloc_en !== 1'b0) begin errors++; $display("FAIL reset_alloc1: got %0d expected 0", inst_PRF[1].alloc_en); end
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        probe(1'b0, 5'd5, p);
        checks++; if (p !== prn_t'(5)) begin errors++; $display("FAIL reset_rat0_r5: got %0d expected 5", p); end
        probe(1'b1, 5'd5, p);
        checks++; if (p !== prn_t'(37)) begin errors++; $display("FAIL reset_rat1_r5: got %0d expected 37", p); end
    endtask

    task automatic test_single();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(40));
        free_PRN[1] = prn_t'(41);
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d expected 1", inst_dispatch[0].valid); end
        checks++; if (inst_dispatch[0].rega_prn !== prn_t'(1)) begin errors++; $display("FAIL single_srca: got %0d expected 1", inst_dispatch[0].rega_prn); end
        checks++; if (inst_dispatch[0].regb_prn !== prn_t'(2)) begin errors++; $display("FAIL single_srcb: got %0d expected 2", inst_dispatch[0].regb_prn); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b1) begin errors++; $display("FAIL single_alloc: got %0d expected 1", inst_PRF[0].alloc_en); end
        checks++; if (inst_PRF[0].new_PRN !== prn_t'(40)) begin errors++; $display("FAIL single_new: got %0d expected 40", inst_PRF[0].new_PRN); end
        checks++; if (inst_PRF[0].old_PRN !== prn_t'(3)) begin errors++; $display("FAIL single_old: got %0d expected 3", inst_PRF[0].old_PRN); end
        checks++; if (inst_dispatch[0].alu_func !== ALU_ADDQ) begin errors++; $display("FAIL single_func: got %0d expected %0d", inst_dispatch[0].alu_func, ALU_ADDQ); end
        checks++; if (inst_PRF[1].alloc_en !== 1'b0) begin errors++; $display("FAIL single_unused_free: got %0d expected 0", inst_PRF[1].alloc_en); end
        probe(1'b0, 5'd3, p);
        checks++; if (p !== prn_t'(40)) begin errors++; $display("FAIL single_rat0_r3: got %0d expected 40", p); end
        probe(1'b1, 5'd3, p);
        checks++; if (p !== prn_t'(35)) begin errors++; $display("FAIL single_rat1_r3: got %0d expected 35", p); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(40));
        set_slot(1, 1'b0, op_inst(6'h10, 5'd3, 5'd4, 7'h20, 5'd3), prn_t'(41));
        #1;
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(40)) begin errors++; $display("FAIL b2b_srca_bypass: got %0d expected 40", inst_dispatch[1].rega_prn); end
        checks++; if (inst_dispatch[1].regb_prn !== prn_t'(4)) begin errors++; $display("FAIL b2b_srcb: got %0d expected 4", inst_dispatch[1].regb_prn); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(40)) begin errors++; $display("FAIL b2b_old1: got %0d expected 40", inst_PRF[1].old_PRN); end
        checks++; if (inst_PRF[1].new_PRN !== prn_t'(41)) begin errors++; $display("FAIL b2b_new1: got %0d expected 41", inst_PRF[1].new_PRN); end
        checks++; if (inst_PRF[0].old_PRN !== prn_t'(3)) begin errors++; $display("FAIL b2b_old0: got %0d expected 3", inst_PRF[0].old_PRN); end
        probe(1'b0, 5'd3, p);
        checks++; if (p !== prn_t'(41)) begin errors++; $display("FAIL b2b_collision_rat: got %0d expected 41", p); end
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd6, 5'd6, 7'h20, 5'd7), prn_t'(50));
        set_slot(1, 1'b0, op_inst(6'h10, 5'd8, 5'd7, 7'h20, 5'd9), prn_t'(51));
        #1;
        checks++; if (inst_dispatch[1].regb_prn !== prn_t'(50)) begin errors++; $display("FAIL b2b_srcb_bypass: got %0d expected 50", inst_dispatch[1].regb_prn); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(9)) begin errors++; $display("FAIL b2b_old_nobypass: got %0d expected 9", inst_PRF[1].old_PRN); end
        probe(1'b0, 5'd9, p);
        checks++; if (p !== prn_t'(51)) begin errors++; $display("FAIL b2b_rat0_r9: got %0d expected 51", p); end
    endtask

    task automatic test_zero_dest();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h11, 5'd31, 5'd31, 7'h20, 5'd31), prn_t'(60));
        set_slot(1, 1'b0, op_inst(6'h10, 5'd31, 5'd5, 7'h20, 5'd6), prn_t'(61));
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0d expected 1", inst_dispatch[0].valid); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL zero_alloc: got %0d expected 0", inst_PRF[0].alloc_en); end
        checks++; if (inst_dispatch[0].rega_prn !== prn_t'(31)) begin errors++; $display("FAIL zero_src: got %0d expected 31", inst_dispatch[0].rega_prn); end
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(31)) begin errors++; $display("FAIL zero_no_bypass: got %0d expected 31", inst_dispatch[1].rega_prn); end
        checks++; if (inst_PRF[1].new_PRN !== prn_t'(61)) begin errors++; $display("FAIL zero_slot1_new: got %0d expected 61", inst_PRF[1].new_PRN); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(6)) begin errors++; $display("FAIL zero_slot1_old: got %0d expected 6", inst_PRF[1].old_PRN); end
        probe(1'b0, 5'd31, p);
        checks++; if (p !== prn_t'(31)) begin errors++; $display("FAIL zero_rat_r31: got %0d expected 31", p); end
        probe(1'b0, 5'd6, p);
        checks++; if (p !== prn_t'(61)) begin errors++; $display("FAIL zero_rat_r6: got %0d expected 61", p); end
    endtask

    task automatic test_mispredict();
        do_reset();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(40));
        @(negedge clock);
        clear_inputs();
        mispredict_thread_0 = 1'b1;
        set_slot(0, 1'b0, op_inst(6'h10, 5'd5, 5'd6, 7'h20, 5'd7), prn_t'(60));
        set_slot(1, 1'b1, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(61));
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b0) begin errors++; $display("FAIL mp_t0_valid: got %0d expected 0", inst_dispatch[0].valid); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL mp_t0_alloc: got %0d expected 0", inst_PRF[0].alloc_en); end
        checks++; if (inst_dispatch[1].valid !== 1'b1) begin errors++; $display("FAIL mp_t1_valid: got %0d expected 1", inst_dispatch[1].valid); end
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(33)) begin errors++; $display("FAIL mp_t1_srca: got %0d expected 33", inst_dispatch[1].rega_prn); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(35)) begin errors++; $display("FAIL mp_t1_old: got %0d expected 35", inst_PRF[1].old_PRN); end
        checks++; if (inst_PRF[1].new_PRN !== prn_t'(61)) begin errors++; $display("FAIL mp_t1_new: got %0d expected 61", inst_PRF[1].new_PRN); end
        probe(1'b0, 5'd3, p);
        checks++; if (p !== prn_t'(3)) begin errors++; $display("FAIL mp_restore_r3: got %0d expected 3", p); end
        probe(1'b0, 5'd7, p);
        checks++; if (p !== prn_t'(7)) begin errors++; $display("FAIL mp_squashed_r7: got %0d expected 7", p); end
        probe(1'b1, 5'd3, p);
        checks++; if (p !== prn_t'(61)) begin errors++; $display("FAIL mp_t1_r3: got %0d expected 61", p); end
        probe(1'b1, 5'd5, p);
        checks++; if (p !== prn_t'(37)) begin errors++; $display("FAIL mp_t1_r5: got %0d expected 37", p); end
    endtask

    task automatic test_both_mispredict();
        @(negedge clock);
        clear_inputs();
        RRAT_arr[0][4]      = prn_t'(90);
        mispredict_thread_0 = 1'b1;
        mispredict_thread_1 = 1'b1;
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd8), prn_t'(62));
        set_slot(1, 1'b1, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd8), prn_t'(63));
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b0) begin errors++; $display("FAIL both_valid0: got %0d expected 0", inst_dispatch[0].valid); end
        checks++; if (inst_dispatch[1].valid !== 1'b0) begin errors++; $display("FAIL both_valid1: got %0d expected 0", inst_dispatch[1].valid); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL both_alloc0: got %0d expected 0", inst_PRF[0].alloc_en); end
        checks++; if (inst_PRF[1].alloc_en !== 1'b0) begin errors++; $display("FAIL both_alloc1: got %0d expected 0", inst_PRF[1].alloc_en); end
        probe(1'b1, 5'd3, p);
        checks++; if (p !== prn_t'(35)) begin errors++; $display("FAIL both_t1_r3: got %0d expected 35", p); end
        probe(1'b0, 5'd4, p);
        checks++; if (p !== prn_t'(90)) begin errors++; $display("FAIL both_t0_r4: got %0d expected 90", p); end
        default_rrat();
    endtask

    task automatic test_mixed();
        do_reset();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd3), prn_t'(40));
        set_slot(1, 1'b1, op_inst(6'h10, 5'd3, 5'd4, 7'h20, 5'd5), prn_t'(41));
        #1;
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(35)) begin errors++; $display("FAIL mixed_srca: got %0d expected 35", inst_dispatch[1].rega_prn); end
        checks++; if (inst_dispatch[1].regb_prn !== prn_t'(36)) begin errors++; $display("FAIL mixed_srcb: got %0d expected 36", inst_dispatch[1].regb_prn); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(37)) begin errors++; $display("FAIL mixed_old1: got %0d expected 37", inst_PRF[1].old_PRN); end
        checks++; if (inst_PRF[0].new_PRN !== prn_t'(40)) begin errors++; $display("FAIL mixed_new0: got %0d expected 40", inst_PRF[0].new_PRN); end
        probe(1'b0, 5'd3, p);
        checks++; if (p !== prn_t'(40)) begin errors++; $display("FAIL mixed_t0_r3: got %0d expected 40", p); end
        probe(1'b1, 5'd5, p);
        checks++; if (p !== prn_t'(41)) begin errors++; $display("FAIL mixed_t1_r5: got %0d expected 41", p); end
        probe(1'b1, 5'd3, p);
        checks++; if (p !== prn_t'(35)) begin errors++; $display("FAIL mixed_t1_r3: got %0d expected 35", p); end
    endtask

    task automatic test_decode();
        logic [31:0] lit_inst;
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, mem_inst(6'h29, 5'd4, 5'd2, 16'd8), prn_t'(70));
        set_slot(1, 1'b0, mem_inst(6'h2d, 5'd4, 5'd2, 16'd0), prn_t'(71));
        #1;
        checks++; if (inst_dispatch[0].rd_mem !== 1'b1) begin errors++; $display("FAIL dec_ldq_rdmem: got %0d expected 1", inst_dispatch[0].rd_mem); end
        checks++; if (inst_dispatch[0].regb_prn !== prn_t'(2)) begin errors++; $display("FAIL dec_ldq_base: got %0d expected 2", inst_dispatch[0].regb_prn); end
        checks++; if (inst_PRF[0].old_PRN !== prn_t'(4)) begin errors++; $display("FAIL dec_ldq_old: got %0d expected 4", inst_PRF[0].old_PRN); end
        checks++; if (inst_dispatch[1].wr_mem !== 1'b1) begin errors++; $display("FAIL dec_stq_wrmem: got %0d expected 1", inst_dispatch[1].wr_mem); end
        checks++; if (inst_PRF[1].alloc_en !== 1'b0) begin errors++; $display("FAIL dec_stq_alloc: got %0d expected 0", inst_PRF[1].alloc_en); end
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(70)) begin errors++; $display("FAIL dec_stq_data_bypass: got %0d expected 70", inst_dispatch[1].rega_prn); end
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, {6'h39, 5'd3, 21'd4}, prn_t'(72));
        set_slot(1, 1'b0, {6'h01, 26'h0}, prn_t'(73));
        #1;
        checks++; if (inst_dispatch[0].cond_branch !== 1'b1) begin errors++; $display("FAIL dec_beq_cond: got %0d expected 1", inst_dispatch[0].cond_branch); end
        checks++; if (inst_dispatch[0].rega_prn !== prn_t'(40)) begin errors++; $display("FAIL dec_beq_src: got %0d expected 40", inst_dispatch[0].rega_prn); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL dec_beq_alloc: got %0d expected 0", inst_PRF[0].alloc_en); end
        checks++; if (inst_dispatch[1].valid !== 1'b0) begin errors++; $display("FAIL dec_illegal_valid: got %0d expected 0", inst_dispatch[1].valid); end
        checks++; if (inst_dispatch[1].illegal !== 1'b1) begin errors++; $display("FAIL dec_illegal_flag: got %0d expected 1", inst_dispatch[1].illegal); end
        checks++; if (inst_PRF[1].alloc_en !== 1'b0) begin errors++; $display("FAIL dec_illegal_alloc: got %0d expected 0", inst_PRF[1].alloc_en); end
        lit_inst = {6'h10, 5'd5, 8'd7, 1'b1, 7'h20, 5'd6};
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, {6'h00, 26'h555}, prn_t'(74));
        set_slot(1, 1'b1, lit_inst, prn_t'(75));
        #1;
        checks++; if (inst_dispatch[0].halt !== 1'b1) begin errors++; $display("FAIL dec_halt: got %0d expected 1", inst_dispatch[0].halt); end
        checks++; if (inst_dispatch[0].valid !== 1'b1) begin errors++; $display("FAIL dec_halt_valid: got %0d expected 1", inst_dispatch[0].valid); end
        checks++; if (inst_dispatch[1].opb_select !== OPB_LIT) begin errors++; $display("FAIL dec_lit_opb: got %0d expected %0d", inst_dispatch[1].opb_select, OPB_LIT); end
        checks++; if (inst_dispatch[1].rega_prn !== prn_t'(41)) begin errors++; $display("FAIL dec_lit_src: got %0d expected 41", inst_dispatch[1].rega_prn); end
        checks++; if (inst_PRF[1].old_PRN !== prn_t'(38)) begin errors++; $display("FAIL dec_lit_old: got %0d expected 38", inst_PRF[1].old_PRN); end
        probe(1'b0, 5'd4, p);
        checks++; if (p !== prn_t'(70)) begin errors++; $display("FAIL dec_rat0_r4: got %0d expected 70", p); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        clear_inputs();
        set_slot(0, 1'b0, op_inst(6'h10, 5'd1, 5'd2, 7'h20, 5'd10), prn_t'(80));
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (inst_dispatch[0].valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0d expected 0", inst_dispatch[0].valid); end
        checks++; if (inst_PRF[0].alloc_en !== 1'b0) begin errors++; $display("FAIL midreset_alloc: got %0d expected 0", inst_PRF[0].alloc_en); end
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        probe(1'b0, 5'd4, p);
        checks++; if (p !== prn_t'(4)) begin errors++; $display("FAIL midreset_r4: got %0d expected 4", p); end
        probe(1'b0, 5'd10, p);
        checks++; if (p !== prn_t'(10)) begin errors++; $display("FAIL midreset_r10: got %0d expected 10", p); end
        probe(1'b1, 5'd6, p);
        checks++; if (p !== prn_t'(38)) begin errors++; $display("FAIL midreset_t1_r6: got %0d expected 38", p); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        default_rrat();
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_dest();
        test_mispredict();
        test_both_mispredict();
        test_mixed();
        test_decode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode-and-rename stage of the 2-wide, 2-thread (SMT) out-of-order core. Sits between fetch (IF_ID) and dispatch/PRF.
- Decodes two Alpha instructions per cycle and renames sources and destination through a per-thread RAT.
- Allocates destinations from the two free PRNs supplied by the PRF.
- Restores a thread's RAT from its retirement RAT on a committed mispredict.

Parameters:
- none (widths come from the `PR_BITS macro).
- Architectural register count is fixed at 32.
- ZERO_REG is fixed at 31.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mispredict_thread_0  input  1  committed mispredicted branch, thread 0.
- mispredict_thread_1  input  1  committed mispredicted branch, thread 1.
- inst_in  input  IF_ID[1:0]  slot 0 is older; fields valid, inst[31:0], NPC, thread_id.
- free_PRN  input  [1:0][`PR_BITS-1:0]  free PRN per slot.
- RRAT_arr  input  RAT_ARR[1:0]  retirement RAT per thread, 32 PRNs each.
- inst_dispatch  output  ID_DISPATCH[1:0]  decoded and renamed instruction to dispatch.
- inst_PRF  output  RAT_PRF[1:0]  allocation info to PRF: alloc_en, new_PRN, old_PRN.

Behaviour:
- State: RAT[2][32] of PRNs.
- Reset (reset==0, async): RAT[0][r]=r and RAT[1][r]=32+r. All outputs invalid/zero while reset is asserted.
- Outputs are combinational from inst_in, free_PRN and the current RAT. There is zero added latency; the RAT updates on the rising edge.
- Decode (per slot):
  - Produces opa/opb selects, alu_func, rd_mem, wr_mem, cond_branch, uncond_branch, halt, illegal.
  - Produces arch rega, regb and dest.
  - Passes NPC and thread_id through.
  - An invalid slot or illegal inst drives valid=0 and no allocation.
- Source rename: src PRN = RAT[tid][arch] for each source.
- Zero register: a source of r31 maps to the RAT value unchanged. A dest of r31 is not renamed: alloc_en=0, and the RAT is untouched.
- Dest rename, valid slot with a real dest:
  - new_PRN=free_PRN[slot], old_PRN=RAT[tid][dest], alloc_en=1.
  - RAT[tid][dest] <= new_PRN at the edge.
- Intra-bundle bypass, slot 1 only, when slot 0 is valid, has a real dest, and both slots are the same thread:
  - A slot 1 source equal to slot 0's dest uses free_PRN[0].
  - If slot 1's dest equals slot 0's dest, slot 1's old_PRN is free_PRN[0].
  - On the write collision, slot 1 wins in the RAT.
- free_PRN[1] is consumed only by slot 1. An unused free PRN is not marked allocated (alloc_en=0).
- Mispredict on thread t:
  - At the edge, RAT[t] <= RRAT_arr[t], overriding any same-cycle rename write for t.
  - In that cycle all outputs for thread t are invalid: valid=0, alloc_en=0.
  - The other thread proceeds normally.
- Both mispredicts asserted together: both RATs are restored and all outputs are invalid.
- Reset asserted mid-operation immediately reinitialises the RAT; inputs are ignored until release.

Test Plan:
- Reset pulse low -> RAT[0][5]=5, RAT[1][5]=37; inst_dispatch valid=0 and inst_PRF alloc_en=0 during reset.
- Slot 0 thread 0 "addq r1,r2,r3" with free_PRN[0]=40 -> srcs PRN 1,2; new_PRN=40, old_PRN=3. Next cycle a read of r3 returns 40.
- Same-thread bundle "addq r1,r2,r3 ; addq r3,r4,r3" with free_PRN={40,41}:
  - slot 1 srcA=40, old_PRN=40, new_PRN=41.
  - RAT[0][3]=41 afterwards.
- Dest r31, e.g. "bis r31,r31,r31" -> alloc_en=0; RAT unchanged; valid=1.
- Rename thread 0 r3->40, then assert mispredict_thread_0 with RRAT_arr[0][3]=3 -> that cycle's thread-0 outputs are invalid. Next cycle r3 reads 3; thread 1 mappings are unchanged.
- Mixed-thread bundle with slot 0=t0 dest r3 and slot 1=t1 src r3 -> slot 1 reads RAT[1][3]=35; no bypass.
